hazard_stall_unit: RTL and testbench

- Stall/flush generator for the 5-stage RISC-V pipeline; the producer side of the operand-forwarding path.
- It covers the cases forwarding cannot resolve: load-use, taken branch/jump redirect, and data-memory wait-states.
- It drives the pipeline-register enables and clears for the F/D/E/M/W boundaries.
- It keeps a wait-state FSM, a timeout detector and saturating performance counters.

---
 rtl/hazard_stall_unit_pkg.sv | 13 +
 rtl/hazard_stall_unit_sat_counter.sv | 22 ++
 rtl/hazard_stall_unit.sv | 129 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall unit.
// State encodings, the x0 register index and the default wait limit.
package hazard_stall_unit_pkg;

   typedef enum logic {
      HZ_RUN  = 1'b0,
      HZ_WAIT = 1'b1
   } hz_state_t;

   localparam logic [4:0] REG_X0 = 5'h00;
   localparam int MAX_WAIT_DEF = 16;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at MAX instead of wrapping.
module hazard_stall_unit_sat_counter #(
   parameter int           W   = 32,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en && (q != MAX)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush generator for the 5-stage pipeline: load-use, redirect,
// data-memory wait-states, wait timeout and performance counters.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       SourceReg1_D,
   input  logic [4:0]       SourceReg2_D,
   input  logic [4:0]       DestRegE,
   input  logic             MemReadE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   hz_state_t  state;
   hz_state_t  state_nxt;
   logic       mem_wait;
   logic       load_use;
   logic       timeout_q;
   logic [7:0] wait_cnt;

   assign mem_wait = MemReqM & ~MemReadyM;
   assign load_use = MemReadE & (DestRegE != REG_X0) &
                     ((DestRegE == SourceReg1_D) |
                      (DestRegE == SourceReg2_D));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HZ_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         HZ_RUN:  state_nxt = mem_wait ? HZ_WAIT : HZ_RUN;
         HZ_WAIT: state_nxt = mem_wait ? HZ_WAIT : HZ_RUN;
         default: state_nxt = HZ_RUN;
      endcase
   end

   // Stalls follow mem_wait directly so the freeze starts with the request.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!rst) begin
         if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   hazard_stall_unit_sat_counter #(
      .W   (8),
      .MAX (WAIT_MAX)
   ) u_wait_cnt (
      .clk (clk),
      .rst (rst),
      .clr (~mem_wait),
      .en  (mem_wait),
      .q   (wait_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else if (mem_wait && (wait_cnt == WAIT_MAX)) begin
         timeout_q <= 1'b1;
      end
   end

   assign MemTimeout = timeout_q;

   hazard_stall_unit_sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .en  (StallF),
      .q   (StallCount)
   );

   hazard_stall_unit_sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .en  (FlushD | FlushE),
      .q   (FlushCount)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit (MAX_WAIT=4).
// Outputs packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
module tb_hazard_stall_unit;
   import hazard_stall_unit_pkg::*;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       SourceReg1_D;
   logic [4:0]       SourceReg2_D;
   logic [4:0]       DestRegE;
   logic             MemReadE;
   logic             PCSrcE;
   logic             MemReqM;
   logic             MemReadyM;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic             MemTimeout;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [6:0] O_NONE = 7'b0000000;
   localparam logic [6:0] O_LU   = 7'b1100010;
   localparam logic [6:0] O_BR   = 7'b0000110;
   localparam logic [6:0] O_MW   = 7'b1111001;

   hazard_stall_unit #(
      .MAX_WAIT (4),
      .CNT_W    (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .SourceReg1_D (SourceReg1_D),
      .SourceReg2_D (SourceReg2_D),
      .DestRegE     (DestRegE),
      .MemReadE     (MemReadE),
      .PCSrcE       (PCSrcE),
      .MemReqM      (MemReqM),
      .MemReadyM    (MemReadyM),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .StallM       (StallM),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushW       (FlushW),
      .MemTimeout   (MemTimeout),
      .StallCount   (StallCount),
      .FlushCount   (FlushCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic br, input logic req,
                        input logic rdy);
      MemReadE     = rd;
      DestRegE     = d;
      SourceReg1_D = s1;
      SourceReg2_D = s2;
      PCSrcE       = br;
      MemReqM      = req;
      MemReadyM    = rdy;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("rst_forces_zero", 32'(outs()), 32'(O_NONE));
      tick();
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("reset_stallcnt", StallCount, 0);
      check("reset_flushcnt", FlushCount, 0);
      check("reset_timeout", 32'(MemTimeout), 0);
      check("reset_idle", 32'(outs()), 32'(O_NONE));

      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      check("lu_rs1", 32'(outs()), 32'(O_LU));
      tick();
      drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      check("lu_one_cycle", 32'(outs()), 32'(O_NONE));
      check("lu_stallcnt", StallCount, 1);
      check("lu_flushcnt", FlushCount, 1);

      drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
      check("lu_rs2", 32'(outs()), 32'(O_LU));
      tick();

      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("x0_no_hazard", 32'(outs()), 32'(O_NONE));
      drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0);
      check("mismatch", 32'(outs()), 32'(O_NONE));
      tick();
      check("idle_stallcnt", StallCount, 2);
      check("idle_flushcnt", FlushCount, 2);

      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
      check("branch_over_lu", 32'(outs()), 32'(O_BR));
      tick();
      check("br_stallcnt", StallCount, 2);
      check("br_flushcnt", FlushCount, 3);

      // wait-state with a redirect and load-use pending underneath
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
         check("memwait", 32'(outs()), 32'(O_MW));
         tick();
      end
      check("memwait_state", 32'(dut.state), 32'(HZ_WAIT));
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check("mem_ready", 32'(outs()), 32'(O_NONE));
      tick();
      check("mw_state_run", 32'(dut.state), 32'(HZ_RUN));
      check("mw_stallcnt", StallCount, 5);
      check("mw_flushcnt", FlushCount, 3);
      check("mw_no_timeout", 32'(MemTimeout), 0);

      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      check("pre_rst_stallcnt", StallCount, 7);
      check("pre_rst_state", 32'(dut.state), 32'(HZ_WAIT));
      rst = 1'b1;
      #1;
      check("rst_mid_wait_outs", 32'(outs()), 32'(O_NONE));
      tick();
      check("rst_stallcnt", StallCount, 0);
      check("rst_flushcnt", FlushCount, 0);
      check("rst_state", 32'(dut.state), 32'(HZ_RUN));
      rst = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();

      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 3) check("to_not_yet", 32'(MemTimeout), 0);
         if (i == 5) check("to_raised", 32'(MemTimeout), 1);
      end
      check("to_still_stall", 32'(outs()), 32'(O_MW));
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      tick();
      check("to_sticky", 32'(MemTimeout), 1);
      check("to_ready_outs", 32'(outs()), 32'(O_NONE));
      check("to_stallcnt", StallCount, 6);
      rst = 1'b1;
      tick();
      check("to_cleared", 32'(MemTimeout), 0);
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
